// File: rtl/date_entry.sv
// Six-digit BCD date entry: debounced pushbuttons step a cursor through a shadow copy of
// the date, and the shadow is committed to the visible date only after all six digits are entered.
module date_entry #(
    parameter int unsigned  DEBOUNCE_CYCLES = 500000,
    parameter logic [23:0]  RESET_DATE      = 24'h030200
) (
    input  logic        MAX10_CLK1_50,
    input  logic        RESET,
    input  logic [1:0]  KEY,
    input  logic [7:0]  SW,
    output logic [23:0] date,
    output logic [2:0]  cursor,
    output logic        editing,
    output logic        updated,
    output logic        digit_err
);

    localparam int unsigned NKEY  = 2;
    localparam int unsigned NDIG  = 6;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       TOP_DIGIT = 3'd5;
    localparam logic [3:0]       MAX_BCD   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // SW[6:4] carry no function
    logic unused_sw;
    assign unused_sw = &{1'b0, SW[6:4]};

    logic             clk;
    assign clk = MAX10_CLK1_50;

    // Synchronizers
    logic [NKEY-1:0]  key_s1_q, key_s2_q;
    logic [4:0]       sw_s1_q,  sw_s2_q;

    // Debouncers and press detection
    logic [CNT_W-1:0] cnt_q [NKEY];
    logic [CNT_W-1:0] cnt_d [NKEY];
    logic [NKEY-1:0]  stable_q, stable_d;
    logic [NKEY-1:0]  stable_dly_q;
    logic [NKEY-1:0]  press_q, press_d;

    // Control path
    state_t           state_q, state_d;
    logic [23:0]      shadow_q, shadow_d;
    logic [23:0]      date_q, date_d;
    logic [2:0]       cursor_q, cursor_d;
    logic             editing_q, editing_d;
    logic             updated_q, updated_d;
    logic             digit_err_q, digit_err_d;

    logic             enter_ev;
    logic             cancel_ev;
    logic             edit_en;
    logic [3:0]       sw_digit;

    // Counter runs only while the synchronized level disagrees with the accepted level
    always_comb begin
        for (int i = 0; i < NKEY; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (key_s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = key_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        press_d = stable_dly_q & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            key_s1_q     <= '1;
            key_s2_q     <= '1;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            stable_q     <= '1;
            stable_dly_q <= '1;
            press_q      <= '0;
            for (int i = 0; i < NKEY; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            key_s1_q     <= KEY;
            key_s2_q     <= key_s1_q;
            sw_s1_q      <= {SW[7], SW[3:0]};
            sw_s2_q      <= sw_s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= press_d;
            for (int i = 0; i < NKEY; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Cancel wins over a simultaneous enter
    assign cancel_ev = press_q[1];
    assign enter_ev  = press_q[0] & ~press_q[1];
    assign edit_en   = sw_s2_q[4];
    assign sw_digit  = sw_s2_q[3:0];

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        date_d      = date_q;
        cursor_d    = cursor_q;
        updated_d   = 1'b0;
        digit_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enter_ev && edit_en) begin
                    state_d  = S_EDIT;
                    shadow_d = date_q;
                    cursor_d = TOP_DIGIT;
                end
            end
            S_EDIT: begin
                if (cancel_ev) begin
                    state_d  = S_IDLE;
                    cursor_d = TOP_DIGIT;
                end else if (enter_ev) begin
                    if (sw_digit <= MAX_BCD) begin
                        for (int i = 0; i < NDIG; i++) begin
                            if (cursor_q == 3'(i)) begin
                                shadow_d[4*i +: 4] = sw_digit;
                            end
                        end
                        if (cursor_q == 3'd0) begin
                            state_d = S_COMMIT;
                        end else begin
                            cursor_d = cursor_q - 3'd1;
                        end
                    end else begin
                        digit_err_d = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                date_d    = shadow_q;
                updated_d = 1'b1;
                cursor_d  = TOP_DIGIT;
                state_d   = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                cursor_d = TOP_DIGIT;
            end
        endcase

        editing_d = (state_d == S_EDIT);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            shadow_q    <= RESET_DATE;
            date_q      <= RESET_DATE;
            cursor_q    <= TOP_DIGIT;
            editing_q   <= 1'b0;
            updated_q   <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            date_q      <= date_d;
            cursor_q    <= cursor_d;
            editing_q   <= editing_d;
            updated_q   <= updated_d;
            digit_err_q <= digit_err_d;
        end
    end

    assign date      = date_q;
    assign cursor    = cursor_q;
    assign editing   = editing_q;
    assign updated   = updated_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_date_entry.sv
// Directed bench for date_entry with a short debounce interval; expected values are
// worked out by hand from the key/switch sequence.
module tb_date_entry;

    localparam int unsigned DEB = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  key;
    logic [7:0]  sw;
    logic [23:0] date;
    logic [2:0]  cursor;
    logic        editing;
    logic        updated;
    logic        digit_err;

    int n_checks;
    int n_fail;
    int upd_cnt;
    int err_cnt;

    date_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .RESET_DATE      (24'h030200)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RESET         (rst),
        .KEY           (key),
        .SW            (sw),
        .date          (date),
        .cursor        (cursor),
        .editing       (editing),
        .updated       (updated),
        .digit_err     (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (updated === 1'b1)   upd_cnt++;
        if (digit_err === 1'b1) err_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the given active-low pattern long enough to debounce, then release fully
    task automatic press(input logic [1:0] pattern);
        key = pattern;
        step(10);
        key = 2'b11;
        step(10);
    endtask

    initial begin
        logic [3:0] digits [6];
        n_checks = 0;
        n_fail   = 0;
        upd_cnt  = 0;
        err_cnt  = 0;
        digits[0] = 4'd0; digits[1] = 4'd9; digits[2] = 4'd0;
        digits[3] = 4'd6; digits[4] = 4'd2; digits[5] = 4'd1;

        rst = 1'b1;
        key = 2'b11;
        sw  = 8'h00;
        step(3);
        rst = 1'b0;
        step(20);
        check("reset_date",    32'(date),    32'h030200);
        check("reset_cursor",  32'(cursor),  32'd5);
        check("reset_editing", 32'(editing), 32'd0);
        check("reset_updated", 32'(upd_cnt), 32'd0);
        check("reset_err",     32'(err_cnt), 32'd0);

        // Enter edit; effect lands DEB+3 edges after KEY is first sampled low
        sw  = 8'h80;
        key = 2'b10;
        step(DEB + 3);
        check("latency_before", 32'(editing), 32'd0);
        step(1);
        check("latency_at",     32'(editing), 32'd1);
        check("enter_cursor",   32'(cursor),  32'd5);
        key = 2'b11;
        step(10);

        // SW[7] dropped during entry must not abort
        for (int i = 0; i < 6; i++) begin
            sw = {4'h0, digits[i]};
            press(2'b10);
            if (i < 5) begin
                check("entry_editing", 32'(editing), 32'd1);
                check("entry_cursor",  32'(cursor),  32'(4 - i));
                check("entry_date",    32'(date),    32'h030200);
            end
        end
        check("commit_editing", 32'(editing), 32'd0);
        check("commit_cursor",  32'(cursor),  32'd5);
        check("commit_date",    32'(date),    32'h090621);
        check("commit_updated", 32'(upd_cnt), 32'd1);

        // Bounce shorter than the debounce interval at cursor 3
        sw = 8'h80;
        press(2'b10);
        sw = 8'h81;
        press(2'b10);
        sw = 8'h82;
        press(2'b10);
        check("pre_glitch_cursor", 32'(cursor), 32'd3);
        key = 2'b10;
        step(3);
        key = 2'b11;
        step(10);
        check("glitch_cursor",  32'(cursor),  32'd3);
        check("glitch_editing", 32'(editing), 32'd1);
        check("glitch_err",     32'(err_cnt), 32'd0);

        // Non-BCD digit rejected
        sw = 8'h8C;
        press(2'b10);
        check("bad_digit_err",     32'(err_cnt), 32'd1);
        check("bad_digit_cursor",  32'(cursor),  32'd3);
        check("bad_digit_editing", 32'(editing), 32'd1);

        press(2'b01);
        check("cancel_editing", 32'(editing), 32'd0);
        check("cancel_cursor",  32'(cursor),  32'd5);
        check("cancel_date",    32'(date),    32'h090621);
        check("cancel_updated", 32'(upd_cnt), 32'd1);

        // Cancel in IDLE and enter with SW[7] low are both ignored
        press(2'b01);
        check("idle_cancel", 32'(editing), 32'd0);
        sw = 8'h00;
        press(2'b10);
        check("idle_no_enable", 32'(editing), 32'd0);

        // Both keys together act as cancel only
        sw = 8'h80;
        press(2'b10);
        check("both_pre_editing", 32'(editing), 32'd1);
        sw = 8'h87;
        press(2'b00);
        check("both_editing", 32'(editing), 32'd0);
        check("both_cursor",  32'(cursor),  32'd5);
        check("both_date",    32'(date),    32'h090621);
        check("both_err",     32'(err_cnt), 32'd1);

        // Reset mid-edit after two digits
        sw = 8'h80;
        press(2'b10);
        sw = 8'h83;
        press(2'b10);
        sw = 8'h84;
        press(2'b10);
        check("pre_reset_cursor", 32'(cursor), 32'd3);
        rst = 1'b1;
        step(1);
        check("midreset_date",    32'(date),    32'h030200);
        check("midreset_cursor",  32'(cursor),  32'd5);
        check("midreset_editing", 32'(editing), 32'd0);
        rst = 1'b0;
        step(5);

        // First press after reset still works after a full debounce
        sw = 8'h80;
        press(2'b10);
        check("post_reset_editing", 32'(editing), 32'd1);
        check("post_reset_date",    32'(date),    32'h030200);
        check("total_updated",      32'(upd_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
